// File: rtl/mempipe_arb_pkg.sv
// Shared memory-pipeline definitions: requester indices and the arbitrated op packet.
package mem_defs;

    localparam int MEMPIPE_NREQ     = 3;
    localparam int MEMPIPE_REQ_FILL = 0;
    localparam int MEMPIPE_REQ_STQ  = 1;
    localparam int MEMPIPE_REQ_LDQ  = 2;

    typedef logic [$clog2(MEMPIPE_NREQ)-1:0] t_mempipe_req_id;

    typedef struct packed {
        logic [3:0]  uop;
        logic [39:0] addr;
        logic [1:0]  size;
        logic [5:0]  rob_id;
    } t_mempipe_arb;

endpackage

// File: rtl/mempipe_arb_starve_ctr.sv
// Per-requester starvation counter; flags the requester urgent after
// STARVE_THRESH consecutive lost cycles in which the pipe was available.
module mempipe_starve_ctr #(
    parameter int STARVE_THRESH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    input  logic avail,
    output logic urgent
);

    localparam int CW = $clog2(STARVE_THRESH + 1);

    logic [CW-1:0] cnt;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (gnt || !req) begin
            cnt <= '0;
        end else if (avail && (cnt != CW'(STARVE_THRESH))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign urgent = (cnt == CW'(STARVE_THRESH));

endmodule

// File: rtl/mempipe_arb.sv
// mm0 arbiter for the memory pipe: fixed priority (fill > stq > ldq) with
// starvation promotion, post-fill bubble and stall; registers the winner into mm1.
module mempipe_arb
    import mem_defs::*;
#(
    parameter int NREQ          = MEMPIPE_NREQ,
    parameter int STARVE_THRESH = 8,
    parameter int FILL_BUBBLE   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_mm0,
    input  t_mempipe_arb [NREQ-1:0]       req_pkt_mm0,
    output logic [NREQ-1:0]               gnt_mm0,
    input  logic                          pipe_stall_mm0,
    output logic                          pipe_valid_mm1,
    output t_mempipe_arb                  pipe_pkt_mm1,
    output logic [$clog2(NREQ)-1:0]       pipe_gnt_id_mm1,
    output logic [NREQ-1:0]               urgent
);

    localparam int IDW = $clog2(NREQ);
    localparam int BW  = 2;

    logic [BW-1:0]   bubble_cnt;
    logic            avail;
    logic [NREQ-1:0] urg_req;
    logic [NREQ-1:0] cand;
    logic [IDW-1:0]  gnt_id;

    assign avail = ~reset & ~pipe_stall_mm0 & (bubble_cnt == '0);

    for (genvar i = 0; i < NREQ; i++) begin : g_ctr
        mempipe_starve_ctr #(
            .STARVE_THRESH (STARVE_THRESH)
        ) u_ctr (
            .clk    (clk),
            .reset  (reset),
            .req    (req_mm0[i]),
            .gnt    (gnt_mm0[i]),
            .avail  (avail),
            .urgent (urgent[i])
        );
    end

    // Urgent requesters form their own priority class; if none is urgent the
    // plain request vector is used. Descending scan leaves the lowest index.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        gnt_mm0 = '0;
        gnt_id  = '0;
        urg_req = req_mm0 & urgent;
        cand    = (|urg_req) ? urg_req : req_mm0;
        if (avail) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    gnt_mm0    = '0;
                    gnt_mm0[i] = 1'b1;
                    gnt_id     = IDW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_mm1  <= 1'b0;
            pipe_pkt_mm1    <= '0;
            pipe_gnt_id_mm1 <= '0;
            bubble_cnt      <= '0;
        end else begin
            pipe_valid_mm1 <= |gnt_mm0;
            if (|gnt_mm0) begin
                pipe_pkt_mm1    <= req_pkt_mm0[gnt_id];
                pipe_gnt_id_mm1 <= gnt_id;
            end
            // The bubble keeps draining through stalls.
            if (gnt_mm0[MEMPIPE_REQ_FILL]) begin
                bubble_cnt <= BW'(FILL_BUBBLE);
            end else if (bubble_cnt != '0) begin
                bubble_cnt <= bubble_cnt - 1'b1;
            end
        end
    end

    a_gnt_onehot : assert property (@(posedge clk) $onehot0(gnt_mm0));
    a_gnt_req    : assert property (@(posedge clk) (gnt_mm0 & ~req_mm0) == '0);
    a_gnt_stall  : assert property (@(posedge clk) pipe_stall_mm0 |-> (gnt_mm0 == '0));

endmodule

// File: tb/tb_mempipe_arb.sv
// Directed and randomized checks of mempipe_arb with FILL_BUBBLE 1 and 2 instances.
module tb_mempipe_arb;
    import mem_defs::*;

    localparam int TH    = 8;
    localparam int BOUND = TH + 3 * (1 + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    stall;
    logic [2:0]              req;
    t_mempipe_arb [2:0]      pkt;

    logic [2:0]              gnt, urg, gnt2, urg2;
    logic                    pv, pv2;
    t_mempipe_arb            pp, pp2;
    logic [1:0]              pid, pid2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mempipe_arb #(.NREQ(3), .STARVE_THRESH(TH), .FILL_BUBBLE(1)) dut (
        .clk(clk), .reset(reset), .req_mm0(req), .req_pkt_mm0(pkt), .gnt_mm0(gnt),
        .pipe_stall_mm0(stall), .pipe_valid_mm1(pv), .pipe_pkt_mm1(pp),
        .pipe_gnt_id_mm1(pid), .urgent(urg)
    );

    mempipe_arb #(.NREQ(3), .STARVE_THRESH(TH), .FILL_BUBBLE(2)) dut2 (
        .clk(clk), .reset(reset), .req_mm0(req), .req_pkt_mm0(pkt), .gnt_mm0(gnt2),
        .pipe_stall_mm0(stall), .pipe_valid_mm1(pv2), .pipe_pkt_mm1(pp2),
        .pipe_gnt_id_mm1(pid2), .urgent(urg2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic [2:0] r, input logic s, input logic rs);
        @(negedge clk);
        reset = rs;
        req   = r;
        stall = s;
        #1;
    endtask

    function automatic logic [2:0] lowest(input logic [2:0] v);
        return v & (~v + 3'd1);
    endfunction

    t_mempipe_arb p0, p1, p2;
    t_mempipe_arb exp_pkt;
    logic         exp_pv;
    logic [2:0]   exp_gnt, ucand, gnt_last;
    logic         m_avail;
    int           mcnt [3];
    int           mwait [3];
    int           mbub;
    int           max_wait;
    logic [63:0]  rnd;

    initial begin
        p0 = '{uop: 4'h1, addr: 40'h00_1000_0040, size: 2'd3, rob_id: 6'd5};
        p1 = '{uop: 4'h2, addr: 40'h00_2000_0080, size: 2'd2, rob_id: 6'd17};
        p2 = '{uop: 4'h3, addr: 40'h12_3456_78C0, size: 2'd1, rob_id: 6'd42};
        pkt[0] = p0; pkt[1] = p1; pkt[2] = p2;
        reset = 1'b1; req = '0; stall = 1'b0;

        // Reset: no grant while reset is high, all outputs cleared.
        drive(3'b111, 1'b0, 1'b1);
        chk("rst_gnt", gnt, 3'b000);
        drive(3'b111, 1'b0, 1'b1);
        chk("rst_pv", pv, 1'b0);
        chk("rst_pid", pid, 2'd0);
        chk("rst_pkt", pp, 64'd0);
        chk("rst_urg", urg, 3'b000);

        // 1: solo ldq, one-cycle latency into mm1.
        drive(3'b100, 1'b0, 1'b0);
        chk("t1_gnt", gnt, 3'b100);
        drive(3'b000, 1'b0, 1'b0);
        chk("t1_pv", pv, 1'b1);
        chk("t1_pid", pid, 2'd2);
        chk("t1_pkt", pp, p2);
        chk("t1_idle_gnt", gnt, 3'b000);
        drive(3'b000, 1'b0, 1'b0);

        // 2: all request, fill once, then bubble, stq streak, ldq promoted.
        drive(3'b111, 1'b0, 1'b0);
        chk("t2_fill_gnt", gnt, 3'b001);
        drive(3'b110, 1'b0, 1'b0);
        chk("t2_bubble_gnt", gnt, 3'b000);
        chk("t2_pid", pid, 2'd0);
        chk("t2_pkt", pp, p0);
        chk("t2_ldq_cnt_hold", dut.g_ctr[2].u_ctr.cnt, 4'd1);
        for (int k = 0; k < 7; k++) begin
            drive(3'b110, 1'b0, 1'b0);
            chk("t2_stq_gnt", gnt, 3'b010);
            chk("t2_no_urg", urg, 3'b000);
        end
        drive(3'b110, 1'b0, 1'b0);
        chk("t2_ldq_urg", urg, 3'b100);
        chk("t2_ldq_gnt", gnt, 3'b100);
        drive(3'b010, 1'b0, 1'b0);
        chk("t2_urg_clr", urg, 3'b000);
        chk("t2_ldq_cnt_clr", dut.g_ctr[2].u_ctr.cnt, 4'd0);
        chk("t2_pid_ldq", pid, 2'd2);
        chk("t2_stq_again", gnt, 3'b010);
        drive(3'b000, 1'b0, 1'b0);

        // 3: long stall, counters frozen, stq first once released.
        for (int k = 0; k < 20; k++) begin
            drive(3'b110, 1'b1, 1'b0);
            chk("t3_stall_gnt", gnt, 3'b000);
        end
        chk("t3_stq_cnt", dut.g_ctr[1].u_ctr.cnt, 4'd0);
        chk("t3_ldq_cnt", dut.g_ctr[2].u_ctr.cnt, 4'd0);
        chk("t3_pv", pv, 1'b0);
        chk("t3_urg", urg, 3'b000);
        drive(3'b110, 1'b0, 1'b0);
        chk("t3_release_gnt", gnt, 3'b010);
        drive(3'b000, 1'b0, 1'b0);
        chk("t3_pv_after", pv, 1'b1);
        chk("t3_pid_after", pid, 2'd1);
        drive(3'b000, 1'b0, 1'b0);

        // 4: FILL_BUBBLE=2 instance, fill every cycle, ldq promoted over fill.
        for (int k = 0; k < 24; k++) begin
            drive(3'b101, 1'b0, 1'b0);
            chk("t4_fill_pattern", gnt2, (k % 3 == 0) ? 3'b001 : 3'b000);
        end
        drive(3'b101, 1'b0, 1'b0);
        chk("t4_ldq_urg", urg2, 3'b100);
        chk("t4_ldq_gnt", gnt2, 3'b100);
        drive(3'b101, 1'b0, 1'b0);
        chk("t4_fill_resume", gnt2, 3'b001);
        chk("t4_urg_clr", urg2, 3'b000);
        for (int k = 0; k < 3; k++) drive(3'b000, 1'b0, 1'b0);

        // 5: reset during a bubble with ldq urgent.
        for (int k = 0; k < 15; k++) begin
            drive(3'b101, 1'b0, 1'b0);
            chk("t5_fill_pattern", gnt, (k % 2 == 0) ? 3'b001 : 3'b000);
        end
        drive(3'b101, 1'b0, 1'b0);
        chk("t5_urg_pre", urg, 3'b100);
        chk("t5_bubble_gnt", gnt, 3'b000);
        reset = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, 3'b000);
        drive(3'b110, 1'b0, 1'b0);
        chk("t5_urg_post", urg, 3'b000);
        chk("t5_pv_post", pv, 1'b0);
        chk("t5_bubble_post", dut.bubble_cnt, 2'd0);
        chk("t5_stq_wins", gnt, 3'b010);
        drive(3'b000, 1'b0, 1'b0);

        // 6: random traffic against a behavioural model of the arbiter.
        exp_pkt = p1; exp_pv = 1'b0; gnt_last = '0; mbub = 0; max_wait = 0;
        for (int i = 0; i < 3; i++) begin mcnt[i] = 0; mwait[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || gnt_last[i]) req[i] = ($urandom_range(0, 99) < 45);
                rnd = {$urandom(), $urandom()};
                pkt[i] = t_mempipe_arb'(rnd[$bits(t_mempipe_arb)-1:0]);
            end
            stall = ($urandom_range(0, 99) < 20);
            #1;
            m_avail = !stall && (mbub == 0);
            for (int i = 0; i < 3; i++) ucand[i] = req[i] && (mcnt[i] == TH);
            if (ucand == '0) ucand = req;
            exp_gnt = m_avail ? lowest(ucand) : 3'b000;
            chk("rnd_gnt", gnt, exp_gnt);
            chk("rnd_pv", pv, exp_pv);
            chk("rnd_pkt", pp, exp_pkt);
            exp_pv = |exp_gnt;
            for (int i = 0; i < 3; i++) begin
                if (exp_gnt[i]) exp_pkt = pkt[i];
                if (exp_gnt[i] || !req[i]) begin
                    mcnt[i] = 0;
                    mwait[i] = 0;
                end else if (m_avail) begin
                    if (mcnt[i] < TH) mcnt[i]++;
                    mwait[i]++;
                    if (mwait[i] > max_wait) max_wait = mwait[i];
                end
            end
            if (exp_gnt[0]) mbub = 1;
            else if (mbub > 0) mbub--;
            gnt_last = gnt;
        end
        chk("starve_bound", (max_wait <= BOUND), 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
